// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared encodings for the LSU: FSM states, store/load codes and access sizes.
package ysyx_22040895_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } lsu_state_e;

  localparam logic [1:0] SL_STORE = 2'b01;
  localparam logic [1:0] SL_LOAD  = 2'b10;

  localparam logic [1:0] MU_BYTE   = 2'b00;
  localparam logic [1:0] MU_HALF   = 2'b01;
  localparam logic [1:0] MU_WORD   = 2'b10;
  localparam logic [1:0] MU_DOUBLE = 2'b11;

  function automatic logic is_mem_op(input logic [1:0] sl);
    return (sl == SL_STORE) || (sl == SL_LOAD);
  endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Byte-lane steering for the LSU: alignment check, store mask/data shift,
// and load data shift plus sign extension.
module ysyx_22040895_lsu_align
  import ysyx_22040895_lsu_pkg::*;
(
  input  logic [1:0]  munit_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic        aligned_o,
  output logic [7:0]  wmask_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  bit_off_s;
  logic [7:0]  base_mask_s;
  logic [63:0] rsh_s;

  assign bit_off_s = {off_i, 3'b000};
  assign wdata_o   = wdata_i << bit_off_s;
  assign rsh_s     = rdata_i >> bit_off_s;
  assign wmask_o   = base_mask_s << off_i;

  always_comb begin
    base_mask_s = 8'h01;
    aligned_o   = 1'b1;
    rdata_o     = rsh_s;
    case (munit_i)
      MU_BYTE: begin
        base_mask_s = 8'h01;
        aligned_o   = 1'b1;
        rdata_o     = {{56{rsh_s[7]}}, rsh_s[7:0]};
      end
      MU_HALF: begin
        base_mask_s = 8'h03;
        aligned_o   = (off_i[0] == 1'b0);
        rdata_o     = {{48{rsh_s[15]}}, rsh_s[15:0]};
      end
      MU_WORD: begin
        base_mask_s = 8'h0F;
        aligned_o   = (off_i[1:0] == 2'b00);
        rdata_o     = {{32{rsh_s[31]}}, rsh_s[31:0]};
      end
      MU_DOUBLE: begin
        base_mask_s = 8'hFF;
        aligned_o   = (off_i == 3'b000);
        rdata_o     = rsh_s;
      end
      default: begin
        base_mask_s = 8'h00;
        aligned_o   = 1'b0;
        rdata_o     = rsh_s;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: accepts one access from IDLE, holds a memory request until
// ack or timeout, and reports completion/error with one-cycle pulses.
module ysyx_22040895_lsu
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i_lsu,
  input  logic [1:0]  sl_i_lsu,
  input  logic [1:0]  munit_i_lsu,
  input  logic [63:0] addr_i_lsu,
  input  logic [63:0] wdata_i_lsu,
  output logic        mem_req_o_lsu,
  output logic        mem_we_o_lsu,
  output logic [63:0] mem_addr_o_lsu,
  output logic [63:0] mem_wdata_o_lsu,
  output logic [7:0]  mem_wmask_o_lsu,
  input  logic        mem_ack_i_lsu,
  input  logic [63:0] mem_rdata_i_lsu,
  output logic [63:0] rdata_o_lsu,
  output logic        done_o_lsu,
  output logic        busy_o_lsu,
  output logic        err_o_lsu
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  lsu_state_e   state_q;
  logic [1:0]   sl_q;
  logic [1:0]   munit_q;
  logic [2:0]   off_q;
  logic [CW-1:0] cnt_q;
  logic         mem_req_q;
  logic         mem_we_q;
  logic [63:0]  mem_addr_q;
  logic [63:0]  mem_wdata_q;
  logic [7:0]   mem_wmask_q;
  logic [63:0]  rdata_q;
  logic         done_q;
  logic         err_q;

  logic         accept_s;
  logic [1:0]   munit_sel_s;
  logic [2:0]   off_sel_s;
  logic         aligned_s;
  logic [7:0]   wmask_s;
  logic [63:0]  wdata_sh_s;
  logic [63:0]  rdata_ext_s;

  assign accept_s   = (state_q == S_IDLE) && valid_i_lsu && is_mem_op(sl_i_lsu);
  assign busy_o_lsu = (state_q != S_IDLE) || accept_s;

  // The aligner sees live inputs while idle (to build the request) and the
  // latched access afterwards (to extract load data on ack).
  assign munit_sel_s = (state_q == S_IDLE) ? munit_i_lsu : munit_q;
  assign off_sel_s   = (state_q == S_IDLE) ? addr_i_lsu[2:0] : off_q;

  ysyx_22040895_lsu_align u_align (
    .munit_i   (munit_sel_s),
    .off_i     (off_sel_s),
    .wdata_i   (wdata_i_lsu),
    .rdata_i   (mem_rdata_i_lsu),
    .aligned_o (aligned_s),
    .wmask_o   (wmask_s),
    .wdata_o   (wdata_sh_s),
    .rdata_o   (rdata_ext_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sl_q        <= 2'b00;
      munit_q     <= 2'b00;
      off_q       <= 3'b000;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'h0;
      mem_wdata_q <= 64'h0;
      mem_wmask_q <= 8'h00;
      rdata_q     <= 64'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            sl_q    <= sl_i_lsu;
            munit_q <= munit_i_lsu;
            off_q   <= addr_i_lsu[2:0];
            cnt_q   <= '0;
            if (aligned_s) begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (sl_i_lsu == SL_STORE);
              mem_addr_q  <= {addr_i_lsu[63:3], 3'b000};
              mem_wdata_q <= wdata_sh_s;
              mem_wmask_q <= wmask_s;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack_i_lsu) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (sl_q == SL_LOAD) begin
              rdata_q <= rdata_ext_s;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= S_ERR;
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        S_ERR: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o_lsu   = mem_req_q;
  assign mem_we_o_lsu    = mem_we_q;
  assign mem_addr_o_lsu  = mem_addr_q;
  assign mem_wdata_o_lsu = mem_wdata_q;
  assign mem_wmask_o_lsu = mem_wmask_q;
  assign rdata_o_lsu     = rdata_q;
  assign done_o_lsu      = done_q;
  assign err_o_lsu       = err_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed bench for ysyx_22040895_lsu with ACK_TIMEOUT=4: one task per scenario.
module tb_ysyx_22040895_lsu;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [1:0]  sl;
  logic [1:0]  munit;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [63:0] rdata;
  logic        done;
  logic        busy;
  logic        err;

  int tests;
  int fails;

  ysyx_22040895_lsu #(.ACK_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i_lsu     (valid),
    .sl_i_lsu        (sl),
    .munit_i_lsu     (munit),
    .addr_i_lsu      (addr),
    .wdata_i_lsu     (wdata),
    .mem_req_o_lsu   (mem_req),
    .mem_we_o_lsu    (mem_we),
    .mem_addr_o_lsu  (mem_addr),
    .mem_wdata_o_lsu (mem_wdata),
    .mem_wmask_o_lsu (mem_wmask),
    .mem_ack_i_lsu   (mem_ack),
    .mem_rdata_i_lsu (mem_rdata),
    .rdata_o_lsu     (rdata),
    .done_o_lsu      (done),
    .busy_o_lsu      (busy),
    .err_o_lsu       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; sl = 2'b00; munit = 2'b00;
    addr = 64'h0; wdata = 64'h0; mem_ack = 1'b0; mem_rdata = 64'h0;
    step(); step();
    tests++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
    tests++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL reset_we: got %b want 0", mem_we); end
    tests++; if (mem_wmask !== 8'h00) begin fails++; $display("FAIL reset_wmask: got %h want 00", mem_wmask); end
    tests++; if (mem_addr !== 64'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    tests++; if (mem_wdata !== 64'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    tests++; if (rdata !== 64'h0)    begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    tests++; if ({done, err, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {done, err, busy}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sb();
    valid = 1'b1; sl = 2'b01; munit = 2'b00; addr = 64'h1005; wdata = 64'hAB;
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sb_issue_busy: got %b want 1", busy); end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        // Scramble inputs while in flight; a valid load here must be ignored.
        sl = 2'b10; munit = 2'b11; addr = 64'hFFFF_FFFF_FFFF_FFF8; wdata = 64'h5555_5555_5555_5555;
      end
      if (c == 4) begin valid = 1'b0; mem_ack = 1'b1; end
      if (c == 5) mem_ack = 1'b0;
      tests++; if (mem_req !== (c <= 4)) begin fails++; $display("FAIL sb_req_c%0d: got %b want %b", c, mem_req, (c <= 4)); end
      tests++; if (done !== (c == 5)) begin fails++; $display("FAIL sb_done_c%0d: got %b want %b", c, done, (c == 5)); end
      tests++; if (busy !== (c <= 5)) begin fails++; $display("FAIL sb_busy_c%0d: got %b want %b", c, busy, (c <= 5)); end
      if (c <= 4) begin
        tests++; if (mem_addr !== 64'h1000) begin fails++; $display("FAIL sb_addr_c%0d: got %h want 1000", c, mem_addr); end
        tests++; if (mem_wmask !== 8'h20) begin fails++; $display("FAIL sb_wmask_c%0d: got %h want 20", c, mem_wmask); end
        tests++; if (mem_wdata !== 64'h0000_AB00_0000_0000) begin fails++; $display("FAIL sb_wdata_c%0d: got %h want 0000ab0000000000", c, mem_wdata); end
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL sb_we_c%0d: got %b want 1", c, mem_we); end
      end
    end
    tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL sb_rdata_kept: got %h want 0", rdata); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL sb_err: got %b want 0", err); end
  endtask

  task automatic test_lh();
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_8001_0000;
    valid = 1'b1; sl = 2'b10; munit = 2'b01; addr = 64'h2002; wdata = 64'h0;
    step();
    valid = 1'b0;
    tests++; if ({mem_req, mem_we} !== 2'b10) begin fails++; $display("FAIL lh_req: got %b want 10", {mem_req, mem_we}); end
    tests++; if (mem_addr !== 64'h2000) begin fails++; $display("FAIL lh_addr: got %h want 2000", mem_addr); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL lh_done_early: got %b want 0", done); end
    step();
    mem_ack = 1'b0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL lh_done: got %b want 1", done); end
    tests++; if (rdata !== 64'hFFFF_FFFF_FFFF_8001) begin fails++; $display("FAIL lh_rdata: got %h want ffffffffffff8001", rdata); end
    step();
    tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL lh_after: got %b want 00", {done, busy}); end
    tests++; if (rdata !== 64'hFFFF_FFFF_FFFF_8001) begin fails++; $display("FAIL lh_rdata_hold: got %h want ffffffffffff8001", rdata); end
  endtask

  task automatic test_lw_misaligned();
    valid = 1'b1; sl = 2'b10; munit = 2'b10; addr = 64'h3002;
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lw_busy0: got %b want 1", busy); end
    step();
    valid = 1'b0;
    #1;
    tests++; if ({err, busy, mem_req} !== 3'b110) begin fails++; $display("FAIL lw_err: got %b want 110", {err, busy, mem_req}); end
    step();
    tests++; if ({err, busy, mem_req} !== 3'b000) begin fails++; $display("FAIL lw_after: got %b want 000", {err, busy, mem_req}); end
  endtask

  task automatic test_ld_timeout();
    valid = 1'b1; sl = 2'b10; munit = 2'b11; addr = 64'h4000; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    for (int c = 1; c <= 6; c++) begin
      step();
      valid = 1'b0;
      tests++; if (mem_req !== (c <= 4)) begin fails++; $display("FAIL to_req_c%0d: got %b want %b", c, mem_req, (c <= 4)); end
      tests++; if (err !== (c == 5)) begin fails++; $display("FAIL to_err_c%0d: got %b want %b", c, err, (c == 5)); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL to_done_c%0d: got %b want 0", c, done); end
    end
    tests++; if (rdata !== 64'hFFFF_FFFF_FFFF_8001) begin fails++; $display("FAIL to_rdata: got %h want ffffffffffff8001", rdata); end
  endtask

  task automatic test_ack_at_limit();
    valid = 1'b1; sl = 2'b10; munit = 2'b11; addr = 64'h5000; mem_rdata = 64'h1122_3344_5566_7788;
    for (int c = 1; c <= 5; c++) begin
      step();
      valid = 1'b0;
      if (c == 4) mem_ack = 1'b1;
      if (c == 5) mem_ack = 1'b0;
      tests++; if (done !== (c == 5)) begin fails++; $display("FAIL lim_done_c%0d: got %b want %b", c, done, (c == 5)); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL lim_err_c%0d: got %b want 0", c, err); end
    end
    tests++; if (rdata !== 64'h1122_3344_5566_7788) begin fails++; $display("FAIL lim_rdata: got %h want 1122334455667788", rdata); end
    step();
  endtask

  task automatic test_rst_abort();
    valid = 1'b1; sl = 2'b01; munit = 2'b11; addr = 64'h6008; wdata = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    valid = 1'b0;
    tests++; if ({mem_req, mem_we, mem_wmask} !== 10'b11_1111_1111) begin fails++; $display("FAIL ra_req: got %b want 1111111111", {mem_req, mem_we, mem_wmask}); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; mem_ack = 1'b1;
    tests++; if ({mem_req, done, mem_wmask} !== 10'b0) begin fails++; $display("FAIL ra_after_rst: got %b want 0", {mem_req, done, mem_wmask}); end
    tests++; if (mem_addr !== 64'h0) begin fails++; $display("FAIL ra_addr: got %h want 0", mem_addr); end
    tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL ra_rdata: got %h want 0", rdata); end
    step();
    mem_ack = 1'b0;
    tests++; if ({done, busy, mem_req, err} !== 4'b0000) begin fails++; $display("FAIL ra_idle: got %b want 0000", {done, busy, mem_req, err}); end
    step();
    tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL ra_idle2: got %b want 00", {done, busy}); end
  endtask

  task automatic test_noop();
    logic [1:0] codes [2];
    codes[0] = 2'b00; codes[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; sl = codes[i]; munit = 2'b00; addr = 64'h7000;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL noop%0d_busy: got %b want 0", i, busy); end
      step(); step();
      tests++; if ({busy, mem_req, done, err} !== 4'b0000) begin fails++; $display("FAIL noop%0d_idle: got %b want 0000", i, {busy, mem_req, done, err}); end
    end
    valid = 1'b0;
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sb();
    test_lh();
    test_lw_misaligned();
    test_ld_timeout();
    test_ack_at_limit();
    test_rst_abort();
    test_noop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
